// File: rtl/tone_detector_if.sv
// tone_detector_if: DAC sample tap and tone result bundle.
// master drives the sample stream, slave is the detector.
interface tone_detector_if;
  logic        enable;
  logic [7:0]  sample;
  logic [1:0]  tone;
  logic        tone_valid;
  logic        tone_change;
  logic [15:0] period;

  modport master (
    output enable, sample,
    input  tone, tone_valid, tone_change, period
  );

  modport slave (
    input  enable, sample,
    output tone, tone_valid, tone_change, period
  );
endinterface

// File: rtl/tone_detector.sv
// tone_detector: times sawtooth wrap-arounds on the DAC bus,
// classifies the period as C / D# / A / NONE and debounces it.
module tone_detector #(
  parameter int PERIOD_C  = 38168,
  parameter int PERIOD_DS = 32154,
  parameter int PERIOD_A  = 22727,
  parameter int TOL       = 1024,
  parameter int TIMEOUT   = 49152
) (
  input logic            clk,
  input logic            nRst,
  tone_detector_if.slave bus
);

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_C    = 2'd1;
  localparam logic [1:0] T_DS   = 2'd2;
  localparam logic [1:0] T_A    = 2'd3;

  localparam logic [15:0] NOM_C  = 16'(PERIOD_C);
  localparam logic [15:0] NOM_DS = 16'(PERIOD_DS);
  localparam logic [15:0] NOM_A  = 16'(PERIOD_A);
  localparam logic [15:0] TOL_W  = 16'(TOL);
  localparam logic [15:0] TO_W   = 16'(TIMEOUT);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        prev_msb_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] period_q, period_d;
  logic [1:0]  cand_q, cand_d;
  logic [1:0]  tone_q, tone_d;
  logic        chg_q;

  logic        wrap;
  logic        timeout;
  logic [15:0] p_meas;
  logic [1:0]  code;

  // |p - nom| <= TOL, done in 17-bit signed so nothing wraps
  function automatic logic near(
    input logic [15:0] p,
    input logic [15:0] nom
  );
    logic signed [16:0] d;
    d = $signed({1'b0, p}) - $signed({1'b0, nom});
    if (d < 17'sd0)
      d = -d;
    return d <= $signed({1'b0, TOL_W});
  endfunction

  assign wrap    = prev_msb_q & ~bus.sample[7];
  assign timeout = (cnt_q == TO_W);
  assign p_meas  = (cnt_q == 16'hFFFF) ? cnt_q
                                       : cnt_q + 16'd1;

  // classify the period that would close on this cycle; A has priority
  always_comb begin
    code = T_NONE;
    priority case (1'b1)
      near(p_meas, NOM_A):  code = T_A;
      near(p_meas, NOM_DS): code = T_DS;
      near(p_meas, NOM_C):  code = T_C;
      default:              code = T_NONE;
    endcase
  end

  // state register plus all datapath registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      prev_msb_q <= 1'b0;
      cnt_q      <= '0;
      period_q   <= '0;
      cand_q     <= T_NONE;
      tone_q     <= T_NONE;
      chg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_msb_q <= bus.sample[7];
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      cand_q     <= cand_d;
      tone_q     <= tone_d;
      chg_q      <= (tone_d != tone_q);
    end
  end

  // next state: enable dominates, a wrap beats the timeout
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (wrap) state_d = MEASURE;
        MEASURE: if (!wrap && timeout) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // counter, period capture and debounce
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    cand_d   = cand_q;
    tone_d   = tone_q;
    if (!bus.enable) begin
      cnt_d  = '0;
      cand_d = T_NONE;
      tone_d = T_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
        end
        MEASURE: begin
          if (wrap) begin
            cnt_d    = '0;
            period_d = p_meas;
            if (code == cand_q)
              tone_d = code;
            else
              cand_d = code;
          end else if (timeout) begin
            cnt_d  = '0;
            cand_d = T_NONE;
            tone_d = T_NONE;
          end else begin
            cnt_d = p_meas;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  assign bus.tone        = tone_q;
  assign bus.tone_valid  = (tone_q != T_NONE);
  assign bus.tone_change = chg_q;
  assign bus.period      = period_q;

endmodule
